// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, control FSM states and
// the opcode legality check used by the datapath.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_PASSA = 4'h0,
        OP_PASSB = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_XOR   = 4'h6,
        OP_NOT   = 4'h7,
        OP_ADC   = 4'h8,
        OP_SBB   = 4'h9,
        OP_SHL   = 4'hA,
        OP_SHR   = 4'hB,
        OP_ROL   = 4'hC,
        OP_ROR   = 4'hD,
        OP_MUL   = 4'hE,
        OP_UNDEF = 4'hF
    } opcode_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    // MUL only counts as a real opcode when the multiplier is built in.
    function automatic logic is_defined_op(opcode_t op, logic mul_en);
        return !((op == OP_UNDEF) || ((op == OP_MUL) && !mul_en));
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/handshake and flag bundle between the datapath controller (master)
// and the ALU (slave).
interface alu_pipe_if #(parameter int WIDTH = 8) ();

    logic                in_valid;
    logic                in_ready;
    alu_pkg::opcode_t    opcode;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                out_valid;
    logic                cf;
    logic                of;
    logic                sf;
    logic                zf;
    logic                err;

    modport master (
        output in_valid, opcode, a, b,
        input  in_ready, out_valid, cf, of, sf, zf, err
    );

    modport slave (
        input  in_valid, opcode, a, b,
        output in_ready, out_valid, cf, of, sf, zf, err
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per enabled cycle, WIDTH cycles
// after start. done is raised during the final iteration with the finished
// product already presented combinationally.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_nxt;

    assign addend  = mplier_q[0] ? mcand_q : '0;
    assign acc_nxt = acc_q + addend;
    assign product = acc_nxt;
    assign done    = en && (cnt_q == CW'(1));

    // Iteration registers; the counter counts down to the terminal iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (en) begin
            if (start) begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, a};
                mplier_q <= b;
                cnt_q    <= CW'(WIDTH);
            end else if (cnt_q != '0) begin
                acc_q    <= acc_nxt;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready input, stored carry for multi-word
// arithmetic, sequential multiply, clock-enable freeze and tri-state result.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | ready for a new operation; single-cycle ops complete here
//   MUL_BUSY | shift-add multiply iterating; input not accepted
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              oe,
    alu_pipe_if.slave         bus,
    output wire [WIDTH-1:0]   alu_out
);

    localparam int MSB = WIDTH - 1;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      res_q;
    logic                  cf_q, of_q, sf_q, zf_q, err_q, out_valid_q;
    logic                  accept, mul_start, mul_done;
    logic [2*WIDTH-1:0]    product;
    logic [WIDTH-1:0]      op_res;
    logic                  op_cf, op_of, op_err;
    logic [WIDTH:0]        wide;

    assign bus.in_ready  = en && (state_q == IDLE);
    assign accept        = bus.in_valid && bus.in_ready;
    assign mul_start     = accept && (bus.opcode == OP_MUL) && (MUL_EN != 0);

    // A strobe registered just before a freeze is held and shown once enabled.
    assign bus.out_valid = out_valid_q && en;
    assign bus.cf        = cf_q;
    assign bus.of        = of_q;
    assign bus.sf        = sf_q;
    assign bus.zf        = zf_q;
    assign bus.err       = err_q;
    assign alu_out       = oe ? res_q : {WIDTH{1'bz}};

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (product)
    );

    // FSM state register; frozen while disabled.
    always_ff @(posedge clk) begin
        if (rst)     state_q <= IDLE;
        else if (en) state_q <= state_d;
    end

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (mul_start) state_d = MUL_BUSY;
            MUL_BUSY: if (mul_done)  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Single-cycle result and carry/overflow; undefined opcodes force zero.
    always_comb begin
        op_res = '0;
        op_cf  = 1'b0;
        op_of  = 1'b0;
        wide   = '0;
        op_err = !is_defined_op(bus.opcode, (MUL_EN != 0));
        case (bus.opcode)
            OP_PASSA: op_res = bus.a;
            OP_PASSB: op_res = bus.b;
            OP_AND:   op_res = bus.a & bus.b;
            OP_OR:    op_res = bus.a | bus.b;
            OP_XOR:   op_res = bus.a ^ bus.b;
            OP_NOT:   op_res = ~bus.a;
            OP_ADD, OP_ADC: begin
                wide   = {1'b0, bus.a} + {1'b0, bus.b}
                       + ((bus.opcode == OP_ADC) ? {{WIDTH{1'b0}}, cf_q} : '0);
                op_res = wide[MSB:0];
                op_cf  = wide[WIDTH];
                op_of  = (bus.a[MSB] == bus.b[MSB]) && (op_res[MSB] != bus.a[MSB]);
            end
            OP_SUB, OP_SBB: begin
                wide   = {1'b0, bus.a} - {1'b0, bus.b}
                       - ((bus.opcode == OP_SBB) ? {{WIDTH{1'b0}}, cf_q} : '0);
                op_res = wide[MSB:0];
                op_cf  = wide[WIDTH];
                op_of  = (bus.a[MSB] != bus.b[MSB]) && (op_res[MSB] != bus.a[MSB]);
            end
            OP_SHL: begin op_res = {bus.a[MSB-1:0], 1'b0};       op_cf = bus.a[MSB]; end
            OP_SHR: begin op_res = {1'b0, bus.a[MSB:1]};         op_cf = bus.a[0];   end
            OP_ROL: begin op_res = {bus.a[MSB-1:0], bus.a[MSB]}; op_cf = bus.a[MSB]; end
            OP_ROR: begin op_res = {bus.a[0], bus.a[MSB:1]};     op_cf = bus.a[0];   end
            default: ;
        endcase
        if (op_err) begin
            op_res = '0;
            op_cf  = 1'b0;
            op_of  = 1'b0;
        end
    end

    // Result/flag register: loads on a single-cycle accept or multiply done.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q       <= '0;
            cf_q        <= 1'b0;
            of_q        <= 1'b0;
            sf_q        <= 1'b0;
            zf_q        <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            out_valid_q <= 1'b0;
            if (mul_start) begin
                err_q <= 1'b0;
            end else if (accept) begin
                res_q       <= op_res;
                cf_q        <= op_cf;
                of_q        <= op_of;
                sf_q        <= op_res[MSB];
                zf_q        <= (op_res == '0);
                err_q       <= op_err;
                out_valid_q <= 1'b1;
            end else if (mul_done && (state_q == MUL_BUSY)) begin
                res_q       <= product[MSB:0];
                cf_q        <= |product[2*WIDTH-1:WIDTH];
                of_q        <= |product[2*WIDTH-1:WIDTH];
                sf_q        <= product[MSB];
                zf_q        <= (product[MSB:0] == '0);
                out_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the lab 8-bit ALU: WIDTH-bit operands, extended opcode set, stored carry for multi-word add/subtract, and a multi-cycle shift-add multiply.
- Valid/ready input handshake and a one-cycle OUT_VALID strobe; keeps EN (clock-enable freeze) and OE (tri-state output).
- Sits between a register file/datapath controller and a result bus.

Parameters:
- WIDTH, 8, operand/result width in bits (legal values 4..32).
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as an undefined opcode.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  global enable; 0 freezes all state.
- OE  in  1  output enable; 0 drives ALU_OUT to high-Z.
- IN_VALID  in  1  operands and opcode valid.
- IN_READY  out  1  block can accept an operation.
- OPCODE  in  4  operation select.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ALU_OUT  out  WIDTH  registered result; high-Z when OE=0.
- OUT_VALID  out  1  one-cycle strobe when a new result and flags are registered.
- CF, OF, SF, ZF  out  1 each  carry/borrow, signed overflow, sign, zero (registered).
- ERR  out  1  last operation had an undefined opcode.

Behaviour:
- Reset (RST=1 at a CLK edge, regardless of EN):
  - Result register, all flags, ERR and OUT_VALID go to 0.
  - FSM goes to IDLE; any MUL in progress is aborted and its result discarded.
- Opcodes:
  - 0000 PASSA, 0001 PASSB, 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT A.
  - 1000 ADC (A+B+CF), 1001 SBB (A-B-CF), 1010 SHL A by 1, 1011 SHR A by 1 (logical), 1100 ROL A, 1101 ROR A, 1110 MUL, 1111 undefined.
- Handshake:
  - IN_READY = EN and state==IDLE.
  - An operation is accepted at an edge where IN_VALID and IN_READY are both 1.
- Single-cycle ops:
  - Result and flags are registered at the accepting edge.
  - OUT_VALID=1 for the following cycle (latency 1).
  - Back-to-back accepts every cycle are allowed.
- MUL (FSM IDLE -> MUL_BUSY -> IDLE):
  - A and B are latched at the accepting edge.
  - WIDTH shift-add iterations follow, one per enabled cycle; IN_READY=0 throughout.
  - On the final iteration, the low WIDTH bits go to ALU_OUT and OUT_VALID pulses for one cycle.
  - ALU_OUT and flags hold their previous values while busy.
- Flags (ZF and SF are always computed from the registered result; SF = result MSB):
  - ADD/ADC: CF = unsigned carry-out; OF = signed overflow.
  - SUB/SBB: CF = 1 on borrow (A < B+cin unsigned); OF = signed overflow.
  - ADC/SBB use the CF held in the flag register as carry-in; all other ops ignore it.
  - Logic, PASS and NOT: CF=0, OF=0.
  - SHL/ROL: CF = old A MSB. SHR/ROR: CF = old A LSB. OF=0 for all shifts/rotates.
  - MUL: CF = OF = 1 when the upper WIDTH bits of the 2*WIDTH product are nonzero.
- Undefined opcode (1111, or 1110 when MUL_EN=0):
  - ALU_OUT=0, CF=OF=SF=0, ZF=1, ERR=1, OUT_VALID pulses.
  - ERR clears at the next accepted valid opcode.
- EN=0:
  - No state changes: result, flags, FSM and MUL counter all hold; IN_READY=0; OUT_VALID=0.
  - Deassertion mid-MUL stalls the multiply, which resumes when EN returns.
  - A pending OUT_VALID pulse is emitted in the first enabled cycle.
- OE is purely combinational on the output driver: ALU_OUT=Z while OE=0. Flags, OUT_VALID and internal state are unaffected.
- IN_VALID while busy or EN=0: not accepted; the upstream must hold its operands.

Decomposition:
- alu_pkg contains:
  - typedef enum logic [3:0] opcode_t;
  - typedef enum logic state_t {IDLE, MUL_BUSY};
  - function is_defined_op(opcode_t, mul_en).
- One sub-module, alu_mul_seq (parameter WIDTH):
  - Inputs: start, en.
  - Outputs: done, product[2*WIDTH-1:0].
  - Internal counter of $clog2(WIDTH)+1 bits.

Test Plan (WIDTH=8):
- ADD A=255 B=255 -> ALU_OUT=0xFE, CF=1 OF=0 SF=1 ZF=0, OUT_VALID one cycle after accept.
- ADD A=103 B=30 -> 0x85, OF=1 SF=1 CF=0. Then SUB A=22 B=90 -> 0xBC, CF=1 OF=0 SF=1.
- ADD 255+1 -> 0x00, CF=1 ZF=1. Then ADC 1+1 -> 0x03, CF=0. Then SBB 5-5 with CF=0 -> 0x00, ZF=1.
- MUL 15*17 -> 0xFF CF=0 after 8 busy cycles with IN_READY=0. MUL 16*16 -> 0x00, CF=OF=1, ZF=1.
  - Drop EN for 3 cycles mid-MUL -> done arrives 3 cycles later.
  - Assert RST mid-MUL -> no OUT_VALID; IN_READY=1 next cycle.
- OPCODE=1111 -> ALU_OUT=0, ERR=1, ZF=1. Then XOR 0xF0^0xFF -> 0x0F, ERR=0.
- OE=0 -> ALU_OUT=Z with flags unchanged. OE=1 -> previous result restored. SHL 0x81 -> 0x02 CF=1. ROR 0x01 -> 0x80 CF=1 SF=1.
